// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: opcode encodings, FSM states,
// port-id type and the opcode legality check.
package alu_arbiter_pkg;

    localparam int unsigned InstrWidth  = 32;
    localparam int unsigned PortIdWidth = 1;

    typedef logic [PortIdWidth-1:0] port_id_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

    localparam logic [3:0] AluAnd  = 4'h0;
    localparam logic [3:0] AluOr   = 4'h1;
    localparam logic [3:0] AluAdd  = 4'h2;
    localparam logic [3:0] AluXor  = 4'h3;
    localparam logic [3:0] AluSub  = 4'h6;
    localparam logic [3:0] AluSlt  = 4'h7;
    localparam logic [3:0] AluSltu = 4'h8;

    function automatic logic is_valid_alu_ctrl(input logic [3:0] ctrl);
        logic ok;
        case (ctrl)
            AluAnd, AluOr, AluAdd, AluXor, AluSub, AluSlt, AluSltu: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle combinational ALU; the second operand is either src2 or the immediate.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = InstrWidth
) (
    input  logic [3:0]      ctrl,
    input  logic            alu_src,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [XLEN-1:0] operand_b;

    always_comb begin
        operand_b = alu_src ? imm : src2;
        result    = '0;
        case (ctrl)
            AluAnd:  result = src1 & operand_b;
            AluOr:   result = src1 | operand_b;
            AluAdd:  result = src1 + operand_b;
            AluXor:  result = src1 ^ operand_b;
            AluSub:  result = src1 - operand_b;
            AluSlt:  result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(operand_b))};
            AluSltu: result = {{(XLEN-1){1'b0}}, (src1 < operand_b)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in flight,
// result registered and held until the winning port consumes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned XLEN       = InstrWidth,
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_ctrl,
    input  logic            req0_alu_src,
    input  logic [XLEN-1:0] req0_src1,
    input  logic [XLEN-1:0] req0_src2,
    input  logic [XLEN-1:0] req0_imm,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_ctrl,
    input  logic            req1_alu_src,
    input  logic [XLEN-1:0] req1_src1,
    input  logic [XLEN-1:0] req1_src2,
    input  logic [XLEN-1:0] req1_imm,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic            rsp_err,
    output logic            busy
);

    // Seeding last_grant with the opposite port makes RESET_PRIO win the first tie.
    localparam port_id_t LastGrantReset = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

    arb_state_e      state_q, state_d;
    port_id_t        grant_id_q, last_grant_q, grant_id;
    logic            grant_valid, accept;
    logic [3:0]      ctrl_q;
    logic            alu_src_q;
    logic [XLEN-1:0] src1_q, src2_q, imm_q;
    logic [XLEN-1:0] result_q, alu_result;
    logic            zero_q, err_q, alu_zero;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid && req1_valid) ? ~last_grant_q : port_id_t'(req1_valid);
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid && !rst) begin
                    accept     = 1'b1;
                    req0_ready = (grant_id == 1'b0);
                    req1_ready = (grant_id == 1'b1);
                    state_d    = StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                rsp0_valid = (grant_id_q == 1'b0);
                rsp1_valid = (grant_id_q == 1'b1);
                // Only the granted port's ready can release the response.
                if ((grant_id_q == 1'b0) ? rsp0_ready : rsp1_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_id_q   <= '0;
            last_grant_q <= LastGrantReset;
            ctrl_q       <= '0;
            alu_src_q    <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            imm_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_id_q   <= grant_id;
                last_grant_q <= grant_id;
                ctrl_q       <= (grant_id == 1'b0) ? req0_ctrl    : req1_ctrl;
                alu_src_q    <= (grant_id == 1'b0) ? req0_alu_src : req1_alu_src;
                src1_q       <= (grant_id == 1'b0) ? req0_src1    : req1_src1;
                src2_q       <= (grant_id == 1'b0) ? req0_src2    : req1_src2;
                imm_q        <= (grant_id == 1'b0) ? req0_imm     : req1_imm;
            end
            if (state_q == StExec) begin
                result_q <= alu_result;
                zero_q   <= alu_zero;
                err_q    <= !is_valid_alu_ctrl(ctrl_q);
            end
        end
    end

    alu_arbiter_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .ctrl    (ctrl_q),
        .alu_src (alu_src_q),
        .src1    (src1_q),
        .src2    (src2_q),
        .imm     (imm_q),
        .result  (alu_result),
        .zero    (alu_zero)
    );

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-port requester queues, a grant/latency model and
// an arithmetic reference model feeding an expected-response queue checked by a monitor.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        logic [3:0]  ctrl;
        logic        alu_src;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] imm;
    } op_t;

    typedef struct {
        int          port;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl = '0, req1_ctrl = '0;
    logic        req0_alu_src = 1'b0, req1_alu_src = 1'b0;
    logic [31:0] req0_src1 = '0, req0_src2 = '0, req0_imm = '0;
    logic [31:0] req1_src1 = '0, req1_src2 = '0, req1_imm = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_err, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   bp_mode = 0;
    bit   outstanding = 1'b0;
    logic model_last = 1'b1;
    op_t  rq0[$];
    op_t  rq1[$];
    exp_t sb[$];

    alu_arbiter #(
        .XLEN       (32),
        .RESET_PRIO (0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_ctrl    (req0_ctrl),
        .req0_alu_src (req0_alu_src),
        .req0_src1    (req0_src1),
        .req0_src2    (req0_src2),
        .req0_imm     (req0_imm),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_ctrl    (req1_ctrl),
        .req1_alu_src (req1_alu_src),
        .req1_src1    (req1_src1),
        .req1_src2    (req1_src2),
        .req1_imm     (req1_imm),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_model(input int port, input op_t op);
        exp_t        e;
        logic [31:0] b;
        b        = op.alu_src ? op.imm : op.s2;
        e.port   = port;
        e.err    = 1'b0;
        e.result = '0;
        case (op.ctrl)
            AluAdd:  e.result = op.s1 + b;
            AluSub:  e.result = op.s1 - b;
            AluAnd:  e.result = op.s1 & b;
            AluOr:   e.result = op.s1 | b;
            AluXor:  e.result = op.s1 ^ b;
            AluSlt:  e.result = ($signed(op.s1) < $signed(b)) ? 32'd1 : 32'd0;
            AluSltu: e.result = (op.s1 < b) ? 32'd1 : 32'd0;
            default: e.err = 1'b1;
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    function automatic op_t mk(input logic [3:0] c, input logic a, input logic [31:0] s1,
                               input logic [31:0] s2, input logic [31:0] imm);
        op_t o;
        o.ctrl = c; o.alu_src = a; o.s1 = s1; o.s2 = s2; o.imm = imm;
        return o;
    endfunction

    function automatic op_t cur_op(input logic p);
        if (p) return mk(req1_ctrl, req1_alu_src, req1_src1, req1_src2, req1_imm);
        return mk(req0_ctrl, req0_alu_src, req0_src1, req0_src2, req0_imm);
    endfunction

    task automatic drive(input int p, input logic v, input op_t o);
        if (p == 0) begin
            req0_valid = v; req0_ctrl = o.ctrl; req0_alu_src = o.alu_src;
            req0_src1 = o.s1; req0_src2 = o.s2; req0_imm = o.imm;
        end else begin
            req1_valid = v; req1_ctrl = o.ctrl; req1_alu_src = o.alu_src;
            req1_src1 = o.s1; req1_src2 = o.s2; req1_imm = o.imm;
        end
    endtask

    // Holds valid and operands until req_ready, then moves straight to the next queued op.
    task automatic requester(input int p);
        op_t o;
        int  n;
        forever begin
            @(posedge clk); #1;
            while ((p == 0) ? (rq0.size() > 0) : (rq1.size() > 0)) begin
                if (p == 0) o = rq0.pop_front(); else o = rq1.pop_front();
                drive(p, 1'b1, o);
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!((p == 0) ? req0_ready : req1_ready) && n < 200);
                if (n >= 200) begin
                    errors++;
                    $display("FAIL req_timeout port %0d: no req_ready after %0d cycles, required within 200",
                             p, n);
                end
                @(posedge clk); #1;
            end
            drive(p, 1'b0, mk(4'h0, 1'b0, 32'd0, 32'd0, 32'd0));
        end
    endtask

    initial requester(0);
    initial requester(1);

    initial begin : rsp_driver
        forever begin
            @(posedge clk); #1;
            case (bp_mode)
                1: begin
                    rsp0_ready = 1'($urandom_range(0, 1));
                    rsp1_ready = 1'($urandom_range(0, 1));
                end
                3: begin
                    rsp0_ready = 1'b0;
                    rsp1_ready = 1'b1;
                end
                default: begin
                    rsp0_ready = 1'b1;
                    rsp1_ready = 1'b1;
                end
            endcase
        end
    end

    initial begin : monitor
        logic has, g;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                outstanding = 1'b0;
                model_last  = 1'b1;
            end else if (!outstanding) begin
                has = req0_valid | req1_valid;
                g   = (req0_valid && req1_valid) ? ~model_last : req1_valid;
                check("req_ready_idle", {req1_ready, req0_ready}, has ? (g ? 2'b10 : 2'b01) : 2'b00);
                check("idle_busy_rsp", {busy, rsp1_valid, rsp0_valid}, 3'b000);
                if (has) begin
                    sb.push_back(ref_model(int'(g), cur_op(g)));
                    outstanding = 1'b1;
                    acc_cyc     = cyc;
                    model_last  = g;
                end
            end else begin
                check("req_ready_busy", {req1_ready, req0_ready}, 2'b00);
                check("busy", busy, 1'b1);
                if (cyc >= acc_cyc + 2) begin
                    e = sb[0];
                    check("rsp_valid", {rsp1_valid, rsp0_valid}, (e.port == 1) ? 2'b10 : 2'b01);
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_zero", rsp_zero, e.zero);
                    check("rsp_err", rsp_err, e.err);
                    if ((e.port == 0 && rsp0_ready) || (e.port == 1 && rsp1_ready)) begin
                        void'(sb.pop_front());
                        outstanding = 1'b0;
                    end
                end else begin
                    check("rsp_valid_early", {rsp1_valid, rsp0_valid}, 2'b00);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy}, 5'b0);
        check({tag, "_result"}, rsp_result, 32'd0);
        check({tag, "_flags"}, {rsp_zero, rsp_err}, 2'b00);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(rq0.size() == 0 && rq1.size() == 0 && !req0_valid && !req1_valid &&
                     !outstanding) && n < 5000);
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain_timeout: traffic still pending after %0d cycles, required to finish", n);
        end
    endtask

    function automatic logic [3:0] pick_ctrl();
        case ($urandom_range(0, 8))
            0: return AluAnd;
            1: return AluOr;
            2: return AluAdd;
            3: return AluXor;
            4: return AluSub;
            5: return AluSlt;
            6: return AluSltu;
            7: return 4'hF;
            default: return 4'h5;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 3));
        return $urandom;
    endfunction

    initial begin : main
        int n;
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rq0.push_back(mk(AluAdd, 1'b0, 32'd5, 32'd7, 32'd0));
        drain();

        // Fresh reset so the first tie goes to port 0.
        do_reset();
        rq0.push_back(mk(AluSub, 1'b0, 32'd9, 32'd9, 32'd0));
        rq1.push_back(mk(AluOr, 1'b0, 32'hF0, 32'h0F, 32'd0));
        for (int i = 0; i < 3; i++) begin
            rq0.push_back(mk(pick_ctrl(), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                             pick_operand()));
            rq1.push_back(mk(pick_ctrl(), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                             pick_operand()));
        end
        drain();

        rq1.push_back(mk(AluSlt, 1'b1, 32'd0, 32'h1234, 32'hFFFF_FFFF));
        rq1.push_back(mk(AluSltu, 1'b1, 32'd0, 32'h1234, 32'hFFFF_FFFF));
        drain();

        // Port 0 response held off while port 1 raises ready and has a request waiting.
        bp_mode = 3;
        rq0.push_back(mk(AluAdd, 1'b0, 32'd1, 32'd2, 32'd0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp0_valid && n < 50);
        check("bp_rsp_seen", rsp0_valid, 1'b1);
        rq1.push_back(mk(AluXor, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0));
        repeat (5) @(negedge clk);
        bp_mode = 0;
        drain();

        rq0.push_back(mk(4'hF, 1'b0, 32'd3, 32'd4, 32'd0));
        drain();

        // Reset while the accepted operation sits in EXEC.
        rq0.push_back(mk(AluAdd, 1'b0, 32'd10, 32'd20, 32'd0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_ready && n < 50);
        check("exec_rst_accept", req0_ready, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1 check_reset_outputs("exec_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);

        bp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            op_t o;
            o = mk(pick_ctrl(), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                   pick_operand());
            if ($urandom_range(0, 1) == 0) rq0.push_back(o); else rq1.push_back(o);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
